arb6_rr: RTL and testbench

- Six-way round-robin request arbiter with a registered one-hot grant.
- An OR reduction tells the system that some requester is active. This block decides which requester is served, hands out a single grant, and rotates fairness between requesters.
- It sits between up to six schematic-level request sources and one shared resource.
- Library-macro flavour: small, fully synchronous, no vendor primitives.

---
 rtl/arb6_pkg.sv | 27 ++
 rtl/arb6_rr_pick.sv | 32 +++
 rtl/arb6_rr.sv | 139 +++++++++++++
 tb/tb_arb6_rr.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arb6_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb6_pkg
// Brief    : Shared types, sizes and index helpers for the six-way arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb6_pkg;

    localparam int NREQ  = 6;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb6_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb6_rr_pick
// Brief    : Rotating first-one finder; scans i_start, i_start+1, ... mod 6.
// Revision : 1.0 - initial release
// ============================================================================
module arb6_rr_pick
    import arb6_pkg::*;
(
    input  logic [NREQ-1:0]  i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = i_start;
        w_pos   = i_start;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_found && i_mask[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
            w_pos = next_idx(w_pos);
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb6_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb6_rr
// Brief    : Six-way round-robin arbiter, registered one-hot grant, hold
//            timeout. Optional high-priority mask via ARB6_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb6_rr
    import arb6_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
)(
    input  logic       CK,
    input  logic       CD,
    input  logic [5:0] REQ,
`ifdef ARB6_PRIORITY_EN
    input  logic [5:0] HPRI,
`endif
    output logic [5:0] GNT,
    output logic [2:0] GID,
    output logic       BUSY,
    output logic       ANY,
    output logic       TMO
);

    localparam logic [CNT_W-1:0] c_hold    = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] c_cnt_sat = '1;

    arb_state_t       r_state, w_state_nx;
    logic [IDX_W-1:0] r_ptr, w_ptr_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [NREQ-1:0]  r_gnt, w_gnt_nx;
    logic [IDX_W-1:0] r_gid, w_gid_nx;
    logic             r_busy, w_busy_nx;
    logic             r_tmo, w_tmo_nx;

    logic [NREQ-1:0]  w_mask;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic             w_req_cur;
    logic             w_timeout;
    logic             w_release;

    assign ANY = |REQ;

`ifdef ARB6_PRIORITY_EN
    assign w_mask = (|(REQ & HPRI)) ? (REQ & HPRI) : REQ;
`else
    assign w_mask = REQ;
`endif

    arb6_rr_pick u_pick (
        .i_mask  (w_mask),
        .i_start (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // r_gnt is one-hot at GID while granting, so this is REQ[GID].
    assign w_req_cur = |(REQ & r_gnt);
    assign w_timeout = (HOLD_MAX != 0) && (r_cnt >= c_hold);
    assign w_release = !w_req_cur || w_timeout;

    always_ff @(posedge CK) begin
        if (CD) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_gid   <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_gnt   <= w_gnt_nx;
            r_gid   <= w_gid_nx;
            r_busy  <= w_busy_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nx = GRANT;
            GRANT:   if (w_release) w_state_nx = GAP;
            GAP:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nx  = r_gnt;
        w_gid_nx  = r_gid;
        w_busy_nx = r_busy;
        w_tmo_nx  = 1'b0;
        w_ptr_nx  = r_ptr;
        w_cnt_nx  = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nx  = onehot(w_idx);
                    w_gid_nx  = w_idx;
                    w_busy_nx = 1'b1;
                    w_cnt_nx  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_gnt_nx  = '0;
                    w_busy_nx = 1'b0;
                    w_ptr_nx  = next_idx(r_gid);
                    // A simultaneous drop wins over the timeout.
                    w_tmo_nx  = w_timeout && w_req_cur;
                end else if (r_cnt != c_cnt_sat) begin
                    w_cnt_nx  = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                w_gnt_nx  = '0;
                w_busy_nx = 1'b0;
            end
            default: begin
                w_gnt_nx  = '0;
                w_busy_nx = 1'b0;
            end
        endcase
    end

    assign GNT  = r_gnt;
    assign GID  = r_gid;
    assign BUSY = r_busy;
    assign TMO  = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_arb6_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb6_rr
// Brief    : Directed bench for arb6_rr; instance a uses HOLD_MAX=15,
//            instance b uses HOLD_MAX=4, both fed the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb6_rr;

    logic       clk = 1'b0;
    logic       cd;
    logic [5:0] req;
`ifdef ARB6_PRIORITY_EN
    logic [5:0] hpri;
`endif
    logic [5:0] gnt_a, gnt_b;
    logic [2:0] gid_a, gid_b;
    logic       busy_a, busy_b, any_a, any_b, tmo_a, tmo_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arb6_rr #(.HOLD_MAX(15), .CNT_W(8)) u_dut_a (
        .CK   (clk),
        .CD   (cd),
        .REQ  (req),
`ifdef ARB6_PRIORITY_EN
        .HPRI (hpri),
`endif
        .GNT  (gnt_a),
        .GID  (gid_a),
        .BUSY (busy_a),
        .ANY  (any_a),
        .TMO  (tmo_a)
    );

    arb6_rr #(.HOLD_MAX(4), .CNT_W(8)) u_dut_b (
        .CK   (clk),
        .CD   (cd),
        .REQ  (req),
`ifdef ARB6_PRIORITY_EN
        .HPRI (hpri),
`endif
        .GNT  (gnt_b),
        .GID  (gid_b),
        .BUSY (busy_b),
        .ANY  (any_b),
        .TMO  (tmo_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cd  = 1'b1;
        req = '0;
`ifdef ARB6_PRIORITY_EN
        hpri = '0;
`endif
        tick();
        cd = 1'b0;
    endtask

    initial begin
        int seq [4] = '{2, 5, 2, 5};
        logic [5:0] oh;

        // Reset with every requester active
        cd  = 1'b1;
        req = 6'b111111;
`ifdef ARB6_PRIORITY_EN
        hpri = '0;
`endif
        tick();
        tick();
        check("rst_gnt",  gnt_a,  6'b000000);
        check("rst_gid",  gid_a,  3'd0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_tmo",  tmo_a,  1'b0);
        check("rst_any",  any_a,  1'b1);
        cd = 1'b0;
        tick();
        check("first_gnt",  gnt_a,  6'b000001);
        check("first_busy", busy_a, 1'b1);
        req = '0;
        #1;
        check("any_zero", any_b, 1'b0);

        // Round robin between requesters 2 and 5
        do_reset();
        req = 6'b100100;
        foreach (seq[r]) begin
            oh = 6'b000001 << seq[r];
            tick();
            check("rr_gnt1", gnt_a, oh);
            check("rr_gid",  gid_a, seq[r]);
            tick();
            tick();
            check("rr_gnt3", gnt_a, oh);
            req = 6'b100100 & ~oh;
            tick();
            check("rr_rel_gnt",  gnt_a,  6'b000000);
            check("rr_rel_busy", busy_a, 1'b0);
            check("rr_rel_tmo",  tmo_a,  1'b0);
            check("rr_rel_gid",  gid_a,  seq[r]);
            req = 6'b100100;
            tick();
            check("rr_idle_gnt", gnt_a, 6'b000000);
        end

        // Timeout on b (HOLD_MAX=4); a keeps granting
        do_reset();
        req = 6'b001000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("to_hold", gnt_b, 6'b001000);
        end
        tick();
        check("to_gnt_b",  gnt_b,  6'b000000);
        check("to_tmo_b",  tmo_b,  1'b1);
        check("to_busy_b", busy_b, 1'b0);
        check("to_gnt_a",  gnt_a,  6'b001000);
        check("to_tmo_a",  tmo_a,  1'b0);
        tick();
        check("to_gap_tmo", tmo_b, 1'b0);
        check("to_gap_gnt", gnt_b, 6'b000000);
        tick();
        check("to_regnt",     gnt_b, 6'b001000);
        check("to_regnt_gid", gid_b, 3'd3);

        // Drop coinciding with timeout counts as a drop
        do_reset();
        req = 6'b000010;
        tick();
        check("dt_gid", gid_b, 3'd1);
        tick();
        tick();
        tick();
        req = 6'b000000;
        tick();
        check("dt_gnt",  gnt_b, 6'b000000);
        check("dt_tmo",  tmo_b, 1'b0);
        check("dt_gid2", gid_b, 3'd1);
        req = 6'b000111;
        tick();
        check("dt_gap", gnt_b, 6'b000000);
        tick();
        check("dt_ptr_b", gid_b, 3'd2);
        check("dt_gnt_b", gnt_b, 6'b000100);
        check("dt_ptr_a", gid_a, 3'd2);

        // Clear in the middle of a grant
        do_reset();
        req = 6'b010000;
        tick();
        check("mc_gid", gid_a, 3'd4);
        tick();
        cd = 1'b1;
        tick();
        check("mc_gnt",  gnt_a,  6'b000000);
        check("mc_gid0", gid_a,  3'd0);
        check("mc_busy", busy_a, 1'b0);
        cd  = 1'b0;
        req = 6'b010001;
        tick();
        check("mc_regnt", gnt_a, 6'b000001);
        check("mc_regid", gid_b, 3'd0);

`ifdef ARB6_PRIORITY_EN
        // High-priority mask overrides pointer order
        do_reset();
        req  = 6'b000011;
        hpri = 6'b000010;
        tick();
        check("hp_gid", gid_a, 3'd1);
        check("hp_gnt", gnt_b, 6'b000010);
        hpri = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
